// File: rtl/cdb_broadcaster_pkg.sv
// Shared definitions for the common data bus (CDB).
// Provides the default field widths, the fixed lane count and the helper
// that locates lane L inside an MSB-first packed lane vector
// (lane 0 occupies the most significant slice).
package cdb_broadcaster_pkg;

  localparam int unsigned ROB_IDX_W = 4;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned CDB_LANES = 4;

  // LSB position of lane 'lane' in a packed vector of CDB_LANES slices of
  // 'width' bits each, lane 0 in the top slice.
  function automatic int unsigned lane_lsb(input int unsigned lane,
                                           input int unsigned width);
    return (CDB_LANES - 1 - lane) * width;
  endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result buffer: in-order FIFO with registered occupancy.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   push, push_data   write one entry (ignored when full)
//   pop               drop the head entry (ignored when empty)
//   head              current head entry
//   full, empty       occupancy flags derived from the registered count
//   count             number of stored entries (0..DEPTH)
module cdb_src_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cdb_broadcaster.sv
// Common data bus broadcaster.
// Buffers completed results from N_SRC functional-unit writeback ports and
// each cycle grants up to four buffered heads, round-robin, onto registered
// CDB lanes snooped by the reservation stations.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   src_valid/src_ready  per-source handshake, bit s = source s
//   src_rob_index        source s at [ROB_IDX_W*s +: ROB_IDX_W]
//   src_result           source s at [DATA_W*s +: DATA_W]
//   cdb_valid_flat       lane L at bit 3-L
//   cdb_rob_index_flat   lane L at [ROB_IDX_W*(3-L) +: ROB_IDX_W]
//   cdb_result_flat      lane L at [DATA_W*(3-L) +: DATA_W]
//   busy                 registered: some source buffer holds an entry
module cdb_broadcaster #(
  parameter int unsigned N_SRC      = 6,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned ROB_IDX_W  = cdb_broadcaster_pkg::ROB_IDX_W,
  parameter int unsigned DATA_W     = cdb_broadcaster_pkg::DATA_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_SRC-1:0]          src_valid,
  output logic [N_SRC-1:0]          src_ready,
  input  logic [ROB_IDX_W*N_SRC-1:0] src_rob_index,
  input  logic [DATA_W*N_SRC-1:0]   src_result,
  output logic [3:0]                cdb_valid_flat,
  output logic [4*ROB_IDX_W-1:0]    cdb_rob_index_flat,
  output logic [4*DATA_W-1:0]       cdb_result_flat,
  output logic                      busy
);

  import cdb_broadcaster_pkg::*;

  localparam int unsigned ENTRY_W = ROB_IDX_W + DATA_W;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PTR_W   = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0]           push;
  logic [N_SRC-1:0]           pop;
  logic [N_SRC-1:0]           full;
  logic [N_SRC-1:0]           empty;
  logic [ENTRY_W-1:0]         head  [N_SRC];
  logic [CNT_W-1:0]           count [N_SRC];

  logic [PTR_W-1:0]           rr_ptr;
  logic [PTR_W-1:0]           rr_next;
  logic [CDB_LANES-1:0]       lane_vld;
  logic [PTR_W-1:0]           lane_src [CDB_LANES];

  logic [3:0]                 cv_next;
  logic [4*ROB_IDX_W-1:0]     rob_next;
  logic [4*DATA_W-1:0]        res_next;
  logic                       busy_next;

  // Ready depends only on the registered count, never on src_valid.
  assign src_ready = ~full;
  assign push      = src_valid & src_ready;

  for (genvar s = 0; s < N_SRC; s++) begin : g_src
    cdb_src_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push[s]),
      .push_data ({src_rob_index[ROB_IDX_W*s +: ROB_IDX_W],
                   src_result[DATA_W*s +: DATA_W]}),
      .pop       (pop[s]),
      .head      (head[s]),
      .full      (full[s]),
      .empty     (empty[s]),
      .count     (count[s])
    );
  end

  // Round-robin scan starting at rr_ptr; the first four non-empty sources
  // take lanes 0..3 in scan order and pop at the edge.
  always_comb begin
    int unsigned      sum;
    logic [PTR_W-1:0] idx;
    logic [2:0]       n;
    pop      = '0;
    lane_vld = '0;
    for (int unsigned l = 0; l < CDB_LANES; l++) lane_src[l] = '0;
    rr_next  = rr_ptr;
    n        = '0;
    sum      = 0;
    idx      = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      sum = 32'(rr_ptr) + i;
      if (sum >= N_SRC) sum = sum - N_SRC;
      idx = PTR_W'(sum);
      if (!empty[idx] && (n < 3'(CDB_LANES))) begin
        pop[idx]          = 1'b1;
        lane_vld[n[1:0]]  = 1'b1;
        lane_src[n[1:0]]  = idx;
        rr_next           = (32'(idx) == N_SRC - 1) ? '0 : idx + 1'b1;
        n                 = n + 3'd1;
      end
    end
  end

  // Lane payloads; unused lanes stay all-zero.
  always_comb begin
    cv_next  = '0;
    rob_next = '0;
    res_next = '0;
    for (int unsigned l = 0; l < CDB_LANES; l++) begin
      if (lane_vld[l]) begin
        cv_next[lane_lsb(l, 1)] = 1'b1;
        rob_next[lane_lsb(l, ROB_IDX_W) +: ROB_IDX_W] =
          head[lane_src[l]][ENTRY_W-1 -: ROB_IDX_W];
        res_next[lane_lsb(l, DATA_W) +: DATA_W] =
          head[lane_src[l]][DATA_W-1:0];
      end
    end
  end

  // Occupancy after this edge's push and pop: a buffer ends non-empty if it
  // receives a push, holds two or more, or holds one that is not popped.
  always_comb begin
    busy_next = 1'b0;
    for (int unsigned s = 0; s < N_SRC; s++) begin
      if (push[s] || (count[s] > CNT_W'(1)) ||
          ((count[s] == CNT_W'(1)) && !pop[s]))
        busy_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr             <= '0;
      cdb_valid_flat     <= '0;
      cdb_rob_index_flat <= '0;
      cdb_result_flat    <= '0;
      busy               <= 1'b0;
    end else begin
      rr_ptr             <= rr_next;
      cdb_valid_flat     <= cv_next;
      cdb_rob_index_flat <= rob_next;
      cdb_result_flat    <= res_next;
      busy               <= busy_next;
    end
  end

endmodule
